// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Only the period needs clamping; high-time is stored exactly as loaded.
package clk_div_pkg;

   localparam int DEF_CNT_W  = 26;
   localparam int MIN_PERIOD = 2;

   function automatic logic [31:0] clamp_period(input logic [31:0] p);
      return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
   endfunction

endpackage

// File: rtl/div_shadow_cfg.sv
// Pending/active configuration pair for clk_div_prog.
// A load always lands in pending; pending moves to active only at a boundary.
module div_shadow_cfg
   import clk_div_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DEF_PERIOD = 2_500_000,
   parameter int DEF_HIGH   = 1_250_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high,
   input  logic             boundary,
   output logic [CNT_W-1:0] act_period,
   output logic [CNT_W-1:0] act_high,
   output logic             pend,
   output logic             ack
);

   logic [CNT_W-1:0] pend_period;
   logic [CNT_W-1:0] pend_high;
   logic             apply;

   assign apply = pend & boundary;

   // On a simultaneous load and apply, active takes the old pending values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_period  <= CNT_W'(DEF_PERIOD);
         act_high    <= CNT_W'(DEF_HIGH);
         pend_period <= CNT_W'(DEF_PERIOD);
         pend_high   <= CNT_W'(DEF_HIGH);
         pend        <= 1'b0;
         ack         <= 1'b0;
      end else begin
         ack <= apply;
         if (apply) begin
            act_period <= pend_period;
            act_high   <= pend_high;
         end
         if (load) begin
            pend_period <= CNT_W'(clamp_period(32'(period)));
            pend_high   <= high;
            pend        <= 1'b1;
         end else if (apply) begin
            pend        <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with start-of-period tick.
// Optional macro DIV_SYNC_IN_EN adds i_sync to restart the period.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DEF_PERIOD = 2_500_000,
   parameter int DEF_HIGH   = 1_250_000
) (
   input  logic             i_clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_period,
   input  logic [CNT_W-1:0] i_high,
   input  logic             i_load,
`ifdef DIV_SYNC_IN_EN
   input  logic             i_sync,
`endif
   output logic             o_load_ack,
   output logic             o_pend,
   output logic             o_clk,
   output logic             o_tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] act_period;
   logic [CNT_W-1:0] act_high;
   logic             wrap;
   logic             sync;
   logic             boundary;

`ifdef DIV_SYNC_IN_EN
   assign sync = i_en & i_sync;
`else
   assign sync = 1'b0;
`endif

   assign wrap     = i_en & (cnt == act_period - CNT_W'(1));
   assign boundary = ~i_en | wrap | sync;

   div_shadow_cfg #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
   ) u_cfg (
      .clk        (i_clk),
      .rst_n      (rst_n),
      .load       (i_load),
      .period     (i_period),
      .high       (i_high),
      .boundary   (boundary),
      .act_period (act_period),
      .act_high   (act_high),
      .pend       (o_pend),
      .ack        (o_load_ack)
   );

   // Compare against the current cnt so outputs lag cnt by one cycle
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         o_clk  <= 1'b0;
         o_tick <= 1'b0;
      end else begin
         if (boundary) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         o_clk  <= i_en & (cnt < act_high);
         o_tick <= i_en & (cnt == '0);
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with a per-cycle expected-output queue.
// Expectations come from a behavioural model of the divider.
module tb_clk_div_prog;

   localparam int W = 16;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         en     = 1'b0;
   logic         load   = 1'b0;
   logic [W-1:0] period = '0;
   logic [W-1:0] high   = '0;
   logic         ack;
   logic         pend;
   logic         dclk;
   logic         tick;
`ifdef DIV_SYNC_IN_EN
   logic         sync   = 1'b0;
`endif

   int errors   = 0;
   int checks   = 0;
   int ack_seen = 0;

   typedef struct {
      logic c;
      logic t;
      logic a;
      logic p;
   } exp_t;

   exp_t sb[$];

   int m_cnt;
   int m_per;
   int m_high;
   int m_pper;
   int m_phigh;
   bit m_pend;

   clk_div_prog #(
      .CNT_W      (W),
      .DEF_PERIOD (10),
      .DEF_HIGH   (4)
   ) dut (
      .i_clk      (clk),
      .rst_n      (rst_n),
      .i_en       (en),
      .i_period   (period),
      .i_high     (high),
      .i_load     (load),
`ifdef DIV_SYNC_IN_EN
      .i_sync     (sync),
`endif
      .o_load_ack (ack),
      .o_pend     (pend),
      .o_clk      (dclk),
      .o_tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_per   = 10;
      m_high  = 4;
      m_pper  = 0;
      m_phigh = 0;
      m_pend  = 0;
   endtask

   task automatic step(input bit ld = 0, input int p = 0, input int h = 0);
      exp_t e;
      bit   wrap;
      bit   apply;
      @(negedge clk);
      load   = ld;
      period = W'(p);
      high   = W'(h);
      wrap   = en && (m_cnt == m_per - 1);
      apply  = m_pend && (!en || wrap);
      e.c    = en && (m_cnt < m_high);
      e.t    = en && (m_cnt == 0);
      e.a    = apply;
      m_cnt  = (en && !wrap) ? m_cnt + 1 : 0;
      if (apply) begin
         m_per  = m_pper;
         m_high = m_phigh;
      end
      if (ld) begin
         m_pper  = (p < 2) ? 2 : p;
         m_phigh = h;
         m_pend  = 1;
      end else if (apply) begin
         m_pend  = 0;
      end
      e.p = m_pend;
      sb.push_back(e);
      @(posedge clk);
      #1;
      load = 1'b0;
      e = sb.pop_front();
      chk("o_clk", 32'(dclk), 32'(e.c));
      chk("o_tick", 32'(tick), 32'(e.t));
      chk("o_load_ack", 32'(ack), 32'(e.a));
      chk("o_pend", 32'(pend), 32'(e.p));
      if (ack === 1'b1) ack_seen++;
   endtask

   // Counts one full period from a tick to the next and its high cycles
   task automatic measure(input int per, input int hi, input bit ld = 0,
                          input int p = 0, input int h = 0);
      int g;
      int n;
      int hs;
      g = 0;
      while (tick !== 1'b1 && g < 64) begin
         step();
         g++;
      end
      chk("tick_wait", 32'(g < 64), 32'd1);
      hs = (dclk === 1'b1) ? 1 : 0;
      step(ld, p, h);
      n = 1;
      if (tick !== 1'b1 && dclk === 1'b1) hs++;
      while (tick !== 1'b1 && n < 64) begin
         step();
         n++;
         if (tick !== 1'b1 && dclk === 1'b1) hs++;
      end
      chk("period_len", 32'(n), 32'(per));
      chk("high_time", 32'(hs), 32'(hi));
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_clk", 32'(dclk), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      rst_n = 1'b1;
      en    = 1'b1;

      measure(10, 4);
      measure(10, 4);

      ack_seen = 0;
      measure(10, 4, 1, 6, 3);
      chk("ack_6_3", 32'(ack_seen), 32'd1);
      measure(6, 3);

      ack_seen = 0;
      measure(6, 3, 1, 1, 0);
      measure(2, 0);
      measure(2, 0, 1, 5, 7);
      measure(2, 0);
      measure(5, 5);
      measure(5, 5);
      chk("ack_clamp", 32'(ack_seen), 32'd2);

      ack_seen = 0;
      step(1, 8, 2);
      step(1, 12, 6);
      measure(12, 6);
      chk("ack_overwrite", 32'(ack_seen), 32'd1);

      ack_seen = 0;
      step(1, 7, 3);
      step();
      step();
      en = 1'b0;
      step();
      step();
      step();
      en = 1'b1;
      measure(7, 3);
      chk("ack_disable", 32'(ack_seen), 32'd1);

      ack_seen = 0;
      step();
      step(1, 9, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_clk", 32'(dclk), 32'd0);
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_pend", 32'(pend), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure(10, 4);
      measure(10, 4);
      chk("ack_after_rst", 32'(ack_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
